// File: rtl/output_pkg.sv
// Shared types and constants for the BCD output display stage.
package output_pkg;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DIGITS_DEF = 3;
    localparam int unsigned BCD_W      = 4 * DIGITS_DEF;

    function automatic int unsigned bcd_width(int unsigned digits);
        return 4 * digits;
    endfunction

    // True when DIGITS decimal digits can hold every DATA_W-bit magnitude.
    function automatic bit bcd_fits(int unsigned data_w, int unsigned digits);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            if (p < 64'd1 << 60) p = p * 10;
        end
        return p >= (64'd1 << data_w);
    endfunction

endpackage

// File: rtl/output_bcd_display_if.sv
// Bus-side and display-side signals of the BCD output display stage.
interface output_bcd_display_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIGITS = 3
);
    wire  [DATA_W-1:0]   bus;
    logic                OI;
    logic                signed_mode;
    logic [7*DIGITS-1:0] seg;
    logic [6:0]          sign_seg;
    logic                busy;
    logic                valid;

    modport master (
        inout  bus,
        output OI, signed_mode,
        input  seg, sign_seg, busy, valid
    );

    // The display only ever reads the bus.
    modport slave (
        input  bus, OI, signed_mode,
        output seg, sign_seg, busy, valid
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, DATA_W steps per value.
module bin2bcd_seq
    import output_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [DATA_W-1:0]              mag_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [bcd_width(DIGITS)-1:0]   bcd_o
);
    localparam int unsigned BcdW = bcd_width(DIGITS);
    localparam int unsigned CntW = $clog2(DATA_W + 1);

    logic              run_q;
    logic [CntW-1:0]   cnt_q;
    logic [BcdW-1:0]   bcd_q, bcd_adj, bcd_d;
    logic [DATA_W-1:0] mag_q, mag_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, mag_d} = {bcd_adj[BcdW-2:0], mag_q, 1'b0};
    end

    // High during the final iteration; bcd_o holds the full result after that edge.
    assign done_o = run_q && (cnt_q == CntW'(DATA_W - 1));
    assign busy_o = run_q;
    assign bcd_o  = bcd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            bcd_q <= '0;
            mag_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            bcd_q <= '0;
            mag_q <= mag_i;
        end else if (run_q) begin
            bcd_q <= bcd_d;
            mag_q <= mag_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/seven_seg.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment decoder; non-decimal codes blank.
module seven_seg (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/output_bcd_display.sv
// Bus-latched signed/unsigned value to seven-segment display via sequential BCD conversion.
// Define OUTPUT_LZB_EN to blank leading zero digits (units digit always shown).
module output_bcd_display
    import output_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input logic                 clk,
    input logic                 rst,
    output_bcd_display_if.slave io
);
    localparam int unsigned BcdW = bcd_width(DIGITS);

    if (!bcd_fits(DATA_W, DIGITS)) begin : g_range_chk
        $error("output_bcd_display: DIGITS too small for DATA_W");
    end

    state_e              state_q, state_d;
    logic                neg_in, neg_q, sign_q, valid_q, commit;
    logic                core_busy, core_done;
    logic [DATA_W-1:0]   mag_in;
    logic [BcdW-1:0]     core_bcd, disp_q;
    logic [7*DIGITS-1:0] seg_raw, seg_out;

    always_comb begin
        neg_in = io.signed_mode & io.bus[DATA_W-1];
        mag_in = neg_in ? -io.bus : io.bus;
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_core (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (io.OI),
        .mag_i   (mag_in),
        .busy_o  (core_busy),
        .done_o  (core_done),
        .bcd_o   (core_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // A new load always wins: it aborts a running conversion and restarts the core.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (io.OI) state_d = StConv;
            StConv:  if (io.OI) state_d = StConv;
                     else if (core_done) state_d = StDone;
            StDone:  state_d = io.OI ? StConv : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        commit  = (state_q == StDone);
        io.busy = core_busy | commit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q   <= 1'b0;
            sign_q  <= 1'b0;
            disp_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= commit;
            if (commit) begin
                disp_q <= core_bcd;
                sign_q <= neg_q;
            end
            if (io.OI) neg_q <= neg_in;
        end
    end

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        seven_seg u_seg (
            .digit_i (disp_q[4*i +: 4]),
            .seg_o   (seg_raw[7*i +: 7])
        );
    end

`ifdef OUTPUT_LZB_EN
    logic lead;
`endif

    always_comb begin
        seg_out = seg_raw;
`ifdef OUTPUT_LZB_EN
        lead = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (lead && disp_q[4*i +: 4] == 4'd0) seg_out[7*i +: 7] = SEG_BLANK;
            else lead = 1'b0;
        end
`endif
    end

    assign io.seg      = seg_out;
    assign io.sign_seg = sign_q ? SEG_MINUS : SEG_BLANK;
    assign io.valid    = valid_q;
endmodule

// File: tb/tb_output_bcd_display.sv
// Self-checking bench for output_bcd_display: directed table, corner sequences, random loads.
module tb_output_bcd_display;
    import output_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned DG = 3;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_drv;

    always #5 clk = ~clk;

    output_bcd_display_if #(.DATA_W(DW), .DIGITS(DG)) dif ();
    assign dif.bus = bus_drv;

    output_bcd_display #(.DATA_W(DW), .DIGITS(DG)) dut (
        .clk (clk),
        .rst (rst),
        .io  (dif)
    );

    int nchecks = 0;
    int nerr    = 0;

    // Reference: a load lands on the display 9 edges later unless another load comes first.
    int rem;
    int pend_mag, disp_mag;
    bit pend_neg, disp_neg, exp_valid;

    typedef struct {
        bit         sm;
        logic [7:0] val;
        int         mag;
        bit         neg;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [20:0] exp_seg(input int mag);
        logic [20:0] r;
        int d0, d1, d2;
        d0 = mag % 10;
        d1 = (mag / 10) % 10;
        d2 = (mag / 100) % 10;
        r = {SEG_TAB[d2], SEG_TAB[d1], SEG_TAB[d0]};
`ifdef OUTPUT_LZB_EN
        if (mag < 100) r[20:14] = SEG_BLANK;
        if (mag < 10)  r[13:7]  = SEG_BLANK;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".seg"}, 32'(dif.seg), 32'(exp_seg(disp_mag)));
        check({tag, ".sign"}, 32'(dif.sign_seg), 32'(disp_neg ? SEG_MINUS : SEG_BLANK));
        check({tag, ".busy"}, 32'(dif.busy), 32'(rem > 0));
        check({tag, ".valid"}, 32'(dif.valid), 32'(exp_valid));
    endtask

    task automatic model_reset();
        rem = 0; pend_mag = 0; pend_neg = 0;
        disp_mag = 0; disp_neg = 0; exp_valid = 0;
    endtask

    task automatic step(input string tag, input bit oi, input bit sm, input logic [7:0] v);
        dif.OI = oi;
        dif.signed_mode = sm;
        bus_drv = v;
        @(posedge clk);
        exp_valid = (rem == 1);
        if (rem == 1) begin
            disp_mag = pend_mag;
            disp_neg = pend_neg;
        end
        if (oi) begin
            rem = 9;
            if (sm && v[7]) begin
                pend_mag = 256 - int'(v);
                pend_neg = 1'b1;
            end else begin
                pend_mag = int'(v);
                pend_neg = 1'b0;
            end
        end else if (rem > 0) begin
            rem--;
        end
        #1;
        dif.OI = 1'b0;
        check_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 8'($urandom));
    endtask

    initial begin
        vecs[0] = '{sm: 1'b0, val: 8'd0,   mag: 0,   neg: 1'b0};
        vecs[1] = '{sm: 1'b0, val: 8'd255, mag: 255, neg: 1'b0};
        vecs[2] = '{sm: 1'b1, val: 8'h80,  mag: 128, neg: 1'b1};
        vecs[3] = '{sm: 1'b1, val: 8'hFF,  mag: 1,   neg: 1'b1};
        vecs[4] = '{sm: 1'b0, val: 8'h80,  mag: 128, neg: 1'b0};
        vecs[5] = '{sm: 1'b1, val: 8'h7F,  mag: 127, neg: 1'b0};
        vecs[6] = '{sm: 1'b0, val: 8'hFF,  mag: 255, neg: 1'b0};
        vecs[7] = '{sm: 1'b1, val: 8'hD6,  mag: 42,  neg: 1'b1};

        rst = 1'b1;
        dif.OI = 1'b0;
        dif.signed_mode = 1'b0;
        bus_drv = 8'h00;
        model_reset();
        #1;
        check_outs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: load, wait 9 edges, display must match the hand-computed value.
        foreach (vecs[k]) begin
            step("tbl_load", 1'b1, vecs[k].sm, vecs[k].val);
            idle("tbl_wait", 9);
            check("tbl_valid", 32'(dif.valid), 32'd1);
            check("tbl_seg", 32'(dif.seg), 32'(exp_seg(vecs[k].mag)));
            check("tbl_sign", 32'(dif.sign_seg), 32'(vecs[k].neg ? SEG_MINUS : SEG_BLANK));
        end

        // Abort: second load at E0+4 restarts; only the second value shows, at E0+13.
        step("abort_a", 1'b1, 1'b0, 8'd42);
        idle("abort_b", 3);
        step("abort_c", 1'b1, 1'b0, 8'd7);
        idle("abort_d", 4);
        check("abort_no_valid", 32'(dif.valid), 32'd0);
        idle("abort_e", 5);
        check("abort_valid", 32'(dif.valid), 32'd1);
        check("abort_seg", 32'(dif.seg), 32'(exp_seg(7)));

        // Load in the DONE cycle: old result commits, new one follows 9 edges later.
        step("done_a", 1'b1, 1'b0, 8'd200);
        idle("done_b", 8);
        step("done_c", 1'b1, 1'b1, 8'hF6);
        check("done_valid1", 32'(dif.valid), 32'd1);
        check("done_seg1", 32'(dif.seg), 32'(exp_seg(200)));
        idle("done_d", 9);
        check("done_valid2", 32'(dif.valid), 32'd1);
        check("done_seg2", 32'(dif.seg), 32'(exp_seg(10)));
        check("done_sign2", 32'(dif.sign_seg), 32'(SEG_MINUS));

        // Asynchronous reset in the middle of a conversion.
        step("mrst_a", 1'b1, 1'b1, 8'h9C);
        idle("mrst_b", 5);
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("mrst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outs("mrst_hold");
        idle("mrst_quiet", 10);
        step("mrst_load", 1'b1, 1'b0, 8'd123);
        idle("mrst_conv", 9);
        check("mrst_valid", 32'(dif.valid), 32'd1);
        check("mrst_seg", 32'(dif.seg), 32'(exp_seg(123)));

        // Random loads at random spacing, including aborts and DONE-cycle reloads.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(5) == 0)
                step("rnd", 1'b1, 1'($urandom_range(1)), 8'($urandom));
            else
                step("rnd", 1'b0, 1'b0, 8'($urandom));
        end
        idle("drain", 10);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/output_bcd_display.md
# output_bcd_display

Parametrised successor to the computer's output stage. Latches a DATA_W-bit value from the system bus on OI, converts it to BCD with a sequential shift-add-3 (double dabble) engine, and drives DIGITS seven-segment digits plus a sign digit. It supports signed two's-complement display. The previous result stays on the displays, without flicker, until a new conversion completes.

## Interface
- DATA_W, 8: bus/value width.
- DIGITS, 3: decimal digits driven.
  - Elaboration `$error` unless 10^DIGITS ≥ 2^DATA_W.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus  inout  DATA_W  system bus; read only, never driven (held high-Z).
- OI  input  1  output-in load strobe; bus sampled on the rising edge where OI=1.
- signed_mode  input  1  1 = interpret bus as two's complement; sampled with OI.
- seg  output  7*DIGITS  digit segments, active-low {g,f,e,d,c,b,a}; digit 0 (units) in [6:0].
- sign_seg  output  7  sign digit: minus (7'b0111111) or blank (7'h7F).
- busy  output  1  conversion in progress.
- valid  output  1  one-cycle pulse when the displays update.

## Operation
- States: IDLE, CONV, DONE.
- Load (any state, OI=1):
  - If signed_mode=1 and bus[MSB]=1: mag = two's-complement negation of bus (unsigned DATA_W), neg=1.
  - Otherwise: mag = bus, neg=0.
  - -2^(DATA_W-1) gives mag = 2^(DATA_W-1).
  - On load: bcd=0, iteration cnt=0, state→CONV.
- CONV: each cycle applies add-3 to every BCD nibble ≥5, then shifts {bcd,mag} left by 1 and increments cnt. After DATA_W iterations, state→DONE.
- DONE: commits bcd→display digit registers and neg→sign register, pulses valid, state→IDLE.
- OI during CONV: the current conversion is aborted and restarts with the new value. The display keeps the last committed result.
- OI in the same cycle as DONE: the old result commits (valid pulses), and the new value loads into CONV.
- Unsigned mode: sign_seg always blank.
- Digit encoding for 0–9 is the standard seven_seg mapping.

## Timing
- OI sampled at edge E0.
- busy=1 after E0 through edge E0+DATA_W+1.
- seg, sign_seg and valid update at edge E0+DATA_W+1; for DATA_W=8 that is 9 edges.
- valid is high exactly one cycle, and is 0 in all other cycles.
- Reset values (asynchronous, immediate, including mid-conversion):
  - state=IDLE, busy=0, valid=0, neg=0.
  - All display digits = 0: seg shows "0" in every digit (subject to OUTPUT_LZB_EN).
  - sign_seg = blank.
- After reset deassertion, the first OI is honoured on the first rising edge.

## Configuration
- OUTPUT_LZB_EN defined:
  - Leading-zero blanking: every digit above the most significant non-zero digit is blank (7'h7F).
  - Units digit always shown.
  - Minus sign stays in sign_seg; it is not moved adjacent to the number.
- Not defined: all DIGITS digits always shown, including leading zeros.
- Blanking is combinational on committed digits and adds no latency.

## Structure
- Package output_pkg holds:
  - State enum (IDLE/CONV/DONE).
  - SEG_BLANK=7'h7F and SEG_MINUS=7'b0111111.
  - BCD_W = 4*DIGITS.
- Natural sub-module: bin2bcd_seq. It is the iterative double-dabble core with start/mag in and busy/done/bcd out, parametrised on DATA_W and DIGITS.
- The top level keeps the load/abort logic, display registers, blanking and existing seven_seg instances.

## Test plan
- Reset, then OI with bus=8'd0 → after 9 edges valid pulses.
  - Without LZB: seg shows "000".
  - With LZB: digits 2 and 1 blank, units "0".
  - sign blank.
- signed_mode=0, bus=8'd255 → "255" at E0+9, sign blank, busy high for exactly 9 cycles.
- signed_mode=1, bus=8'h80 → "128" with sign_seg=SEG_MINUS.
  - Same with bus=8'hFF → "001" with minus ("  1" under LZB).
- Load 8'd42, then OI with 8'd7 at E0+4:
  - Display holds the old value; no valid pulse at E0+9.
  - valid at E0+4+9; display "007".
- OI asserted in the DONE cycle:
  - First value commits with valid.
  - Second value appears DATA_W+1 edges later.
- Assert rst at E0+5 mid-conversion:
  - Outputs return to reset values asynchronously.
  - No valid pulse; the next OI converts normally.
